// File: rtl/decode_sequencer_if.sv
// decode_sequencer_if: fetch, redirect and decode handshake bundle for decode_sequencer
// Fetch side:    imem_req/imem_addr out, imem_ack/imem_rdata in.
// Redirect side: redirect_valid/redirect_pc in.
// Decode side:   dec_valid, decoded fields and dec_pc out; dec_ready in.
// Status:        start in; halted and retired out.
interface decode_sequencer_if #(parameter int PC_W = 16);
    logic            start;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            dec_valid;
    logic            dec_ready;
    logic [1:0]      bc;
    logic            ct;
    logic [4:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [13:0]     immediate;
    logic [18:0]     jump_immediate;
    logic [23:0]     system_op;
    logic [PC_W-1:0] dec_pc;
    logic            halted;
    logic [15:0]     retired;
    modport slave (
        input  start, imem_ack, imem_rdata, redirect_valid, redirect_pc, dec_ready,
        output imem_req, imem_addr, dec_valid, bc, ct, opcode, rd, rs1, rs2,
               immediate, jump_immediate, system_op, dec_pc, halted, retired
    );
    modport master (
        output start, imem_ack, imem_rdata, redirect_valid, redirect_pc, dec_ready,
        input  imem_req, imem_addr, dec_valid, bc, ct, opcode, rd, rs1, rs2,
               immediate, jump_immediate, system_op, dec_pc, halted, retired
    );
endinterface

// File: rtl/decode_sequencer.sv
// decode_sequencer: fetches instruction words, presents decoded fields and sequences the PC
// Ports: clk, rst_n (async active-low) and bus (decode_sequencer_if slave modport)
// carrying fetch request/ack, redirect, decoded-instruction handshake and status.
module decode_sequencer #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    decode_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, dec_pc_q, dec_pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [15:0]     retired_q, retired_d;
    logic            is_jump, is_halt;
    logic [PC_W-1:0] jump_off;
    assign is_jump  = ir_q[31:30] == 2'b11;
    assign is_halt  = ir_q[31:30] == 2'b00 && ir_q[28:24] == 5'b11111;
    // Sign-extend from bit 18, then fit to PC_W so the add wraps naturally.
    assign jump_off = PC_W'(signed'(ir_q[18:0]));
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        dec_pc_d  = dec_pc_q;
        retired_d = retired_q;
        if (state_q == IDLE) begin
            if (bus.redirect_valid) pc_d = bus.redirect_pc;
            else if (bus.start) state_d = FETCH;
        end else if (bus.redirect_valid) begin
            // Redirect wins over ack, accept and start alike; in-flight data is dropped.
            pc_d    = bus.redirect_pc;
            state_d = FETCH;
        end else if (state_q == FETCH) begin
            if (bus.imem_ack) begin
                ir_d     = bus.imem_rdata;
                dec_pc_d = pc_q;
                state_d  = ISSUE;
            end
        end else if (state_q == ISSUE) begin
            if (bus.dec_ready) begin
                retired_d = retired_q + 16'd1;
                pc_d      = is_jump ? pc_q + jump_off : pc_q + PC_W'(1);
                state_d   = is_halt ? HALT : FETCH;
            end
        end else if (bus.start) begin
            state_d = FETCH;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            dec_pc_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            dec_pc_q  <= dec_pc_d;
            retired_q <= retired_d;
        end
    end
    assign bus.imem_req       = state_q == FETCH;
    assign bus.imem_addr      = pc_q;
    assign bus.dec_valid      = state_q == ISSUE;
    assign bus.halted         = state_q == HALT;
    assign bus.retired        = retired_q;
    assign bus.dec_pc         = dec_pc_q;
    assign bus.bc             = ir_q[31:30];
    assign bus.ct             = ir_q[29];
    assign bus.opcode         = ir_q[28:24];
    assign bus.rd             = ir_q[23:19];
    assign bus.rs1            = ir_q[18:14];
    assign bus.rs2            = ir_q[13:9];
    assign bus.immediate      = ir_q[13:0];
    assign bus.jump_immediate = ir_q[18:0];
    assign bus.system_op      = ir_q[23:0];
endmodule

// File: tb/tb_decode_sequencer.sv
// tb_decode_sequencer: directed scoreboard bench for decode_sequencer
module tb_decode_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    decode_sequencer_if #(.PC_W(16)) bus();
    decode_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    typedef struct {
        logic [15:0] pc;
        logic [31:0] ir;
        logic [15:0] ret;
    } dexp_t;
    logic [15:0] aq[$];
    dexp_t       dq[$];
    int checks = 0;
    int errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.imem_req && bus.imem_ack) begin
                if (aq.size() == 0) chk("unexpected_fetch", 32'(bus.imem_addr), 32'hFFFF_FFFF);
                else chk("fetch_addr", 32'(bus.imem_addr), 32'(aq.pop_front()));
            end
            if (bus.dec_valid && bus.dec_ready) begin
                if (dq.size() == 0) chk("unexpected_accept", 32'(bus.dec_pc), 32'hFFFF_FFFF);
                else begin
                    dexp_t e;
                    e = dq.pop_front();
                    chk("dec_pc", 32'(bus.dec_pc), 32'(e.pc));
                    chk("retired_before", 32'(bus.retired), 32'(e.ret));
                    chk("bc", 32'(bus.bc), 32'(e.ir[31:30]));
                    chk("ct", 32'(bus.ct), 32'(e.ir[29]));
                    chk("opcode", 32'(bus.opcode), 32'(e.ir[28:24]));
                    chk("rd", 32'(bus.rd), 32'(e.ir[23:19]));
                    chk("rs1", 32'(bus.rs1), 32'(e.ir[18:14]));
                    chk("rs2", 32'(bus.rs2), 32'(e.ir[13:9]));
                    chk("immediate", 32'(bus.immediate), 32'(e.ir[13:0]));
                    chk("jump_immediate", 32'(bus.jump_immediate), 32'(e.ir[18:0]));
                    chk("system_op", 32'(bus.system_op), 32'(e.ir[23:0]));
                end
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic fetch(input logic [31:0] word, input logic [15:0] exp_addr);
        int n = 0;
        aq.push_back(exp_addr);
        while (!bus.imem_req && n < 50) begin tick(); n++; end
        if (!bus.imem_req) chk("fetch_timeout", 32'(bus.imem_req), 32'd1);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = word;
        tick();
        bus.imem_ack = 1'b0;
    endtask
    task automatic accept(input logic [15:0] pc, input logic [31:0] word, input logic [15:0] ret);
        int n = 0;
        dq.push_back('{pc, word, ret});
        while (!bus.dec_valid && n < 50) begin tick(); n++; end
        if (!bus.dec_valid) chk("accept_timeout", 32'(bus.dec_valid), 32'd1);
        bus.dec_ready = 1'b1;
        tick();
        bus.dec_ready = 1'b0;
    endtask
    task automatic redirect(input logic [15:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = pc;
        tick();
        bus.redirect_valid = 1'b0;
    endtask
    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.start = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.dec_ready = 1'b0;
        tick();
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_retired", 32'(bus.retired), 32'd0);
        chk("rst_system_op", 32'(bus.system_op), 32'd0);
        chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); chk("idle_no_req", 32'(bus.imem_req), 32'd0); end
        pulse_start();
        fetch(32'h2308_8800, 16'h0000);
        chk("d_bc", 32'(bus.bc), 32'd0);
        chk("d_ct", 32'(bus.ct), 32'd1);
        chk("d_opcode", 32'(bus.opcode), 32'd3);
        chk("d_rd", 32'(bus.rd), 32'd1);
        chk("d_rs1", 32'(bus.rs1), 32'd2);
        chk("d_rs2", 32'(bus.rs2), 32'd4);
        chk("d_imm", 32'(bus.immediate), 32'h0800);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(bus.dec_valid), 32'd1);
            chk("bp_dec_pc", 32'(bus.dec_pc), 32'd0);
            chk("bp_opcode", 32'(bus.opcode), 32'd3);
            chk("bp_system_op", 32'(bus.system_op), 32'h08_8800);
            chk("bp_retired", 32'(bus.retired), 32'd0);
        end
        accept(16'h0000, 32'h2308_8800, 16'd0);
        chk("after_accept_addr", 32'(bus.imem_addr), 32'd1);
        chk("after_accept_retired", 32'(bus.retired), 32'd1);
        chk("after_accept_valid", 32'(bus.dec_valid), 32'd0);
        redirect(16'h0005);
        fetch(32'hC007_FFFE, 16'h0005);
        accept(16'h0005, 32'hC007_FFFE, 16'd1);
        chk("jump_addr", 32'(bus.imem_addr), 32'd3);
        redirect(16'hFFFF);
        fetch(32'h4000_0000, 16'hFFFF);
        accept(16'hFFFF, 32'h4000_0000, 16'd2);
        chk("wrap_addr", 32'(bus.imem_addr), 32'd0);
        redirect(16'h0007);
        fetch(32'h1F00_0000, 16'h0007);
        accept(16'h0007, 32'h1F00_0000, 16'd3);
        for (int i = 0; i < 2; i++) begin
            chk("halt_halted", 32'(bus.halted), 32'd1);
            chk("halt_req", 32'(bus.imem_req), 32'd0);
            chk("halt_valid", 32'(bus.dec_valid), 32'd0);
            chk("halt_pc", 32'(bus.imem_addr), 32'd8);
            tick();
        end
        pulse_start();
        chk("resume_halted", 32'(bus.halted), 32'd0);
        fetch(32'h0000_0000, 16'h0008);
        accept(16'h0008, 32'h0000_0000, 16'd4);
        chk("pre_coll_retired", 32'(bus.retired), 32'd5);
        aq.push_back(16'h0009);
        bus.imem_rdata = 32'hDEAD_BEEF;
        bus.imem_ack = 1'b1;
        redirect(16'h0040);
        bus.imem_ack = 1'b0;
        chk("coll_valid", 32'(bus.dec_valid), 32'd0);
        chk("coll_req", 32'(bus.imem_req), 32'd1);
        chk("coll_addr", 32'(bus.imem_addr), 32'h0040);
        chk("coll_retired", 32'(bus.retired), 32'd5);
        fetch(32'hC007_FFFE, 16'h0040);
        chk("pre_rst_valid", 32'(bus.dec_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.dec_valid), 32'd0);
        chk("arst_req", 32'(bus.imem_req), 32'd0);
        chk("arst_retired", 32'(bus.retired), 32'd0);
        chk("arst_system_op", 32'(bus.system_op), 32'd0);
        chk("arst_dec_pc", 32'(bus.dec_pc), 32'd0);
        tick();
        tick();
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_req", 32'(bus.imem_req), 32'd0);
            chk("post_rst_halted", 32'(bus.halted), 32'd0);
        end
        chk("aq_drained", 32'(aq.size()), 32'd0);
        chk("dq_drained", 32'(dq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
